lfsr_roll_history: RTL and testbench

//  Parametrised random-number core with a rolling animation and a history buffer.
//  A free-running Galois LFSR feeds a "roll": the displayed value changes at

---
 rtl/lfsr_roll_pkg.sv | 21 ++
 rtl/lfsr_galois.sv | 21 ++
 rtl/lfsr_roll_history.sv | 136 +++++++++++++
 tb/tb_lfsr_roll_history.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_roll_pkg.sv
// Shared types and width helpers for the LFSR roll/history block.
package lfsr_roll_pkg;

  typedef enum logic {S_IDLE, S_ROLL} roll_state_t;

  // Pointer width into a DEPTH-entry ring (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Interval counter width: must hold the longest interval, BASE_DIV*ROLL_STEPS.
  function automatic int div_w(input int base_div, input int roll_steps);
    return $clog2(base_div * roll_steps + 1);
  endfunction

  // Step counter width: counts 0..ROLL_STEPS-1.
  function automatic int step_w(input int roll_steps);
    return (roll_steps > 1) ? $clog2(roll_steps) : 1;
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR, right-shifting: the lsb falls out and, when set, folds TAPS back in.
module lfsr_galois
  import lfsr_roll_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  // Shift register; a nonzero seed with a maximal mask never reaches zero.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)  state <= SEED;
    else if (en)  state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? TAPS : '0);
  end

endmodule

// File: rtl/lfsr_roll_history.sv
// Dice-style roll: LFSR value shown at growing intervals, final value kept in a ring.
module lfsr_roll_history
  import lfsr_roll_pkg::*;
#(
  parameter int                WIDTH      = 4,
  parameter int                DEPTH      = 8,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
  parameter int                ROLL_STEPS = 16,
  parameter int                BASE_DIV   = 250000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_prev,
  input  logic                     i_next,
  output logic [WIDTH-1:0]         o_random_out,
  output logic                     o_busy,
  output logic [$clog2(DEPTH)-1:0] o_view_idx,
  output logic [$clog2(DEPTH):0]   o_hist_count
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DIV_W  = div_w(BASE_DIV, ROLL_STEPS);
  localparam int STEP_W = step_w(ROLL_STEPS);

  roll_state_t                  state_q, state_d;
  logic [LFSR_W-1:0]            lfsr_q;
  logic [DEPTH-1:0][WIDTH-1:0]  hist_q;
  logic [PTR_W-1:0]             wr_ptr_q, view_q, view_d, rd_idx;
  logic [CNT_W-1:0]             count_q;
  logic [STEP_W-1:0]            step_q;
  logic [DIV_W-1:0]             div_q, div_lim;
  logic [WIDTH-1:0]             out_q, rd_val;
  logic                         busy_q, expire, last_step;

  lfsr_galois #(.LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
    .gclk   (i_clk),
    .grst_n (i_rst_n),
    .en     (1'b1),
    .state  (lfsr_q)
  );

  if (WIDTH < LFSR_W) begin : g_lfsr_hi
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:WIDTH];
  end

  // Step k lasts BASE_DIV*(k+1) cycles; div counts 0..limit-1.
  assign div_lim   = DIV_W'(BASE_DIV) * (DIV_W'(step_q) + DIV_W'(1));
  assign expire    = (div_q == div_lim - DIV_W'(1));
  assign last_step = (step_q == STEP_W'(ROLL_STEPS - 1));

  // Browse index: prev goes older, next goes newer, both together cancel.
  always_comb begin
    view_d = view_q;
    if (i_prev && !i_next && (({1'b0, view_q} + CNT_W'(1)) < count_q))
      view_d = view_q + PTR_W'(1);
    else if (i_next && !i_prev && (view_q != '0))
      view_d = view_q - PTR_W'(1);
    rd_idx = wr_ptr_q - PTR_W'(1) - view_d;
    rd_val = (count_q == '0) ? '0 : hist_q[rd_idx];
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state: start always (re)enters ROLL; the last interval returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_ROLL;
      S_ROLL: if (!i_start && expire && last_step) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Roll timing, display, history commit and browse index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist_q   <= '0;
      wr_ptr_q <= '0;
      view_q   <= '0;
      count_q  <= '0;
      step_q   <= '0;
      div_q    <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= (state_d == S_ROLL);
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            step_q <= '0;
            div_q  <= '0;
          end else begin
            view_q <= view_d;
            out_q  <= rd_val;
          end
        end
        S_ROLL: begin
          if (i_start) begin
            step_q <= '0;
            div_q  <= '0;
          end else if (expire) begin
            out_q <= lfsr_q[WIDTH-1:0];
            div_q <= '0;
            if (last_step) begin
              hist_q[wr_ptr_q] <= lfsr_q[WIDTH-1:0];
              wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
              view_q           <= '0;
              step_q           <= '0;
              if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
            end else begin
              step_q <= step_q + STEP_W'(1);
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_random_out = out_q;
  assign o_busy       = busy_q;
  assign o_view_idx   = view_q;
  assign o_hist_count = count_q;

endmodule

// File: tb/tb_lfsr_roll_history.sv
// Directed bench: roll timing, ring history/browse, restart and async reset.
module tb_lfsr_roll_history;

  localparam int          WIDTH = 4, DEPTH = 4, ROLL_STEPS = 4, BASE_DIV = 2;
  localparam logic [15:0] TAPS  = 16'hB400, SEED = 16'hACE1;

  logic       clk = 1'b0, rst_n = 1'b1, start = 1'b0, prev = 1'b0, next = 1'b0;
  logic [3:0] rnd;
  logic       busy;
  logic [1:0] view;
  logic [2:0] cnt;
  int         ecnt, n_chk = 0, n_pass = 0;
  logic [3:0] r [1:6];

  lfsr_roll_history #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LFSR_W(16), .TAPS(TAPS), .SEED(SEED),
    .ROLL_STEPS(ROLL_STEPS), .BASE_DIV(BASE_DIV)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_prev(prev), .i_next(next),
    .o_random_out(rnd), .o_busy(busy), .o_view_idx(view), .o_hist_count(cnt)
  );

  always #5 clk = ~clk;

  // Number of LFSR shifts since reset released.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Low WIDTH bits of the LFSR after n shifts from SEED.
  function automatic logic [3:0] lsb_at(input int n);
    logic [15:0] s;
    s = SEED;
    for (int i = 0; i < n; i++) s = (s >> 1) ^ (s[0] ? TAPS : 16'h0);
    return s[3:0];
  endfunction

  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic p, input logic n);
    start = s; prev = p; next = n;
    step_clk();
    start = 1'b0; prev = 1'b0; next = 1'b0;
  endtask

  // Full uninterrupted roll; returns the value the model says gets committed.
  task automatic do_roll(input string tag, output logic [3:0] v);
    int s;
    pulse(1'b1, 1'b0, 1'b0);
    s = ecnt;
    repeat (20) step_clk();
    v = lsb_at(s + 19);
    chk({tag, "_val"}, rnd, v);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int s, nbusy;
    logic [3:0] e;

    // 1. reset
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out", rnd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("empty_prev_view", view, 0);
    chk("empty_prev_out", rnd, 0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("empty_next_view", view, 0);

    // 2. single roll with interval timing
    pulse(1'b1, 1'b0, 1'b0);
    s = ecnt;
    nbusy = busy ? 1 : 0;
    for (int k = 1; k <= 21; k++) begin
      step_clk();
      if (busy) nbusy++;
      if (k == 1) chk("t2_busy_k1", busy, 1);
      if (k == 2 || k == 6 || k == 12 || k == 20) begin
        e = lsb_at(s + k - 1);
        chk($sformatf("t2_out_k%0d", k), rnd, e);
      end
      if (k == 5) begin
        e = lsb_at(s + 1);
        chk("t2_hold_k5", rnd, e);
      end
    end
    chk("t2_busy_cycles", nbusy, 20);
    chk("t2_busy_end", busy, 0);
    chk("t2_cnt", cnt, 1);
    chk("t2_view", view, 0);
    r[1] = lsb_at(s + 19);
    chk("t2_out_final", rnd, r[1]);

    // 3. fill and overwrite the ring, then browse
    do_roll("roll2", r[2]);
    do_roll("roll3", r[3]);
    do_roll("roll4", r[4]);
    do_roll("roll5", r[5]);
    chk("t3_cnt_sat", cnt, 4);
    pulse(1'b0, 1'b1, 1'b0);
    chk("t3_prev1_view", view, 1);
    chk("t3_prev1_out", rnd, r[4]);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("t3_prev3_view", view, 3);
    chk("t3_prev3_out", rnd, r[2]);
    pulse(1'b0, 1'b1, 1'b0);
    chk("t3_prev4_hold", view, 3);
    repeat (3) pulse(1'b0, 1'b0, 1'b1);
    chk("t3_next_view", view, 0);
    chk("t3_next_out", rnd, r[5]);
    pulse(1'b0, 1'b0, 1'b1);
    chk("t3_next_hold", view, 0);

    // 4. prev+next cancel; start beats prev
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b1);
    chk("t4_both_view", view, 1);
    pulse(1'b1, 1'b1, 1'b0);
    s = ecnt;
    chk("t4_start_busy", busy, 1);
    chk("t4_start_view", view, 1);
    repeat (10) step_clk();
    chk("t4_mid_view", view, 1);
    repeat (10) step_clk();
    r[6] = lsb_at(s + 19);
    chk("t4_commit_view", view, 0);
    chk("t4_commit_out", rnd, r[6]);
    chk("t4_commit_cnt", cnt, 4);

    // 6. async reset mid-roll
    pulse(1'b1, 1'b0, 1'b0);
    repeat (7) step_clk();
    chk("t6_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out", rnd, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cnt", cnt, 0);
    chk("t6_rst_view", view, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 5. restart at cycle 10 of a roll, LFSR sequence restarted from SEED
    pulse(1'b1, 1'b0, 1'b0);
    s = ecnt;
    repeat (9) step_clk();
    pulse(1'b1, 1'b0, 1'b0);
    for (int k = 11; k <= 30; k++) begin
      step_clk();
      if (k == 20) begin
        chk("t5_k20_busy", busy, 1);
        chk("t5_k20_cnt", cnt, 0);
      end
      if (k == 29) chk("t5_k29_busy", busy, 1);
    end
    e = lsb_at(s + 29);
    chk("t5_commit_out", rnd, e);
    chk("t5_commit_cnt", cnt, 1);
    chk("t5_commit_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
